lbeacon_gen: RTL and testbench

Controller-side generator of beacon update messages for the TSN ring. Each configuration request from the control-plane register interface becomes one fixed 4-beat packet on the 134-bit FAST packet bus. The packet carries the new direction, token-bucket, direct-MAC and time-slot-period settings that the addressed node's local control module applies. An optional periodic timer re-sends the current configuration, so nodes that missed an update are refreshed.

---
 rtl/lbeacon_gen_pkg.sv | 40 ++++
 rtl/lbeacon_gen_if.sv | 26 ++
 rtl/lbeacon_timer.sv | 29 ++
 rtl/lbeacon_gen.sv | 159 +++++++++++++++
 tb/tb_lbeacon_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbeacon_gen_pkg.sv
// Shared constants, types and beat helpers for the TSN ring beacon generator.
// Beat layout: [133:132] header code, [131:128] empty-byte count (always 0), [127:0] payload.
package lbeacon_gen_pkg;

    localparam logic [7:0]  LMID       = 8'd1;
    localparam logic [15:0] ETHTYPE    = 16'h9001;
    localparam logic [7:0]  MSG_UPDATE = 8'h02;

    localparam logic [1:0]  HDR_HEAD   = 2'b01;
    localparam logic [1:0]  HDR_BODY   = 2'b11;
    localparam logic [1:0]  HDR_TAIL   = 2'b10;

    localparam int BEAT_W      = 134;
    localparam int PAYLOAD_W   = 128;
    localparam int OFS_HDR     = 132;
    localparam int OFS_EMPTY   = 128;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_B3   = 3'd4
    } state_t;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic        direction;
        logic [15:0] tb_para;
        logic [15:0] tb_depth;
        logic [47:0] direct_mac;
        logic [31:0] slot_period;
    } cfg_t;

    function automatic logic [BEAT_W-1:0] mk_beat(input logic [1:0] hdr,
                                                  input logic [PAYLOAD_W-1:0] payload);
        return {hdr, 4'b0000, payload};
    endfunction

endpackage

// File: rtl/lbeacon_gen_if.sv
// FAST packet bus between the beacon generator (master) and the downstream sink (slave).
interface lbeacon_gen_if;

    logic [133:0] out_data;
    logic         out_data_wr;
    logic         out_data_valid;
    logic         out_data_valid_wr;
    logic         in_ready;

    modport master (
        output out_data,
        output out_data_wr,
        output out_data_valid,
        output out_data_valid_wr,
        input  in_ready
    );

    modport slave (
        input  out_data,
        input  out_data_wr,
        input  out_data_valid,
        input  out_data_valid_wr,
        output in_ready
    );

endinterface

// File: rtl/lbeacon_timer.sv
// Auto-resend period counter: counts 0..period-1 while enabled, pulses expire on the
// terminal count, and returns to 0 on restart or when disabled.
module lbeacon_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        restart,
    input  logic [31:0] period,
    output logic        expire
);

    logic [31:0] cnt;
    logic        term;

    // ">=" keeps the counter from running away if the period is shortened mid-count.
    assign term   = en && (cnt >= (period - 32'd1));
    assign expire = term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !en || term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/lbeacon_gen.sv
// Beacon update generator: turns configuration requests (and periodic resends of the
// last configuration) into fixed 4-beat update packets on the FAST packet bus.
module lbeacon_gen
    import lbeacon_gen_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_wr,
    input  logic [47:0]  cfg_dst_mac,
    input  logic         cfg_direction,
    input  logic [15:0]  cfg_tb_para,
    input  logic [15:0]  cfg_tb_depth,
    input  logic [47:0]  cfg_direct_mac,
    input  logic [31:0]  cfg_slot_period,
    input  logic [31:0]  beacon_period,
    input  logic [47:0]  in_local_mac_id,
    input  logic [47:0]  precision_time,
    lbeacon_gen_if.master pkt,
    output logic         busy,
    output logic [31:0]  out_pkt_cnt,
    output logic [15:0]  overwrite_cnt,
    output state_t       dbg_state
);

    // Handshake: in_ready is looked at only in IDLE with a request pending; when both are
    // high the whole 4-beat packet is committed and its beats leave on consecutive cycles
    // (out_data_wr high B0..B3) whatever in_ready does afterwards.

    state_t       state_q, state_d;
    cfg_t         cfg_in, pend_cfg, shadow_cfg, snap_cfg;
    logic         pend, shadow_valid;
    logic [7:0]   seq, snap_seq;
    logic [47:0]  snap_time;
    logic         consume, tmr_expire, load;
    logic [133:0] data_d;
    logic         wr_d, vwr_d;

    assign cfg_in = '{dst_mac:     cfg_dst_mac,
                      direction:   cfg_direction,
                      tb_para:     cfg_tb_para,
                      tb_depth:    cfg_tb_depth,
                      direct_mac:  cfg_direct_mac,
                      slot_period: cfg_slot_period};

    assign consume = (state_q == ST_IDLE) && pend && pkt.in_ready;
    assign load    = cfg_wr || tmr_expire;

    lbeacon_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      ((beacon_period != 32'd0) && shadow_valid),
        .restart (cfg_wr),
        .period  (beacon_period),
        .expire  (tmr_expire)
    );

    // Request registers; a new cfg_wr takes precedence over a simultaneous timer reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cfg      <= '0;
            shadow_cfg    <= '0;
            shadow_valid  <= 1'b0;
            pend          <= 1'b0;
            overwrite_cnt <= '0;
        end else begin
            if (cfg_wr) begin
                pend_cfg     <= cfg_in;
                shadow_cfg   <= cfg_in;
                shadow_valid <= 1'b1;
            end else if (tmr_expire) begin
                pend_cfg <= shadow_cfg;
            end
            if (load) begin
                pend <= 1'b1;
            end else if (consume) begin
                pend <= 1'b0;
            end
            if (load && pend && !consume && (overwrite_cnt != 16'hFFFF)) begin
                overwrite_cnt <= overwrite_cnt + 16'd1;
            end
        end
    end

    // Send snapshot, time stamp and packet bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_cfg    <= '0;
            snap_seq    <= '0;
            snap_time   <= '0;
            seq         <= '0;
            out_pkt_cnt <= '0;
        end else begin
            if (consume) begin
                snap_cfg <= pend_cfg;
                snap_seq <= seq;
            end
            if (state_q == ST_B0) begin
                snap_time <= precision_time;
            end
            if (state_q == ST_B3) begin
                seq         <= seq + 8'd1;
                out_pkt_cnt <= out_pkt_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = '0;
        wr_d    = 1'b0;
        vwr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (consume) state_d = ST_B0;
            end
            ST_B0: begin
                state_d = ST_B1;
                wr_d    = 1'b1;
                data_d  = mk_beat(HDR_HEAD, {snap_cfg.dst_mac, in_local_mac_id,
                                             ETHTYPE, MSG_UPDATE, snap_seq});
            end
            ST_B1: begin
                state_d = ST_B2;
                wr_d    = 1'b1;
                data_d  = mk_beat(HDR_BODY, {LMID, 7'b0, snap_cfg.direction,
                                             snap_cfg.tb_para, snap_cfg.tb_depth,
                                             snap_cfg.slot_period, 48'b0});
            end
            ST_B2: begin
                state_d = ST_B3;
                wr_d    = 1'b1;
                data_d  = mk_beat(HDR_BODY, {snap_cfg.direct_mac, snap_time, 32'b0});
            end
            ST_B3: begin
                state_d = ST_IDLE;
                wr_d    = 1'b1;
                vwr_d   = 1'b1;
                data_d  = mk_beat(HDR_TAIL, 128'b0);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pkt.out_data          = data_d;
    assign pkt.out_data_wr       = wr_d;
    assign pkt.out_data_valid    = vwr_d;
    assign pkt.out_data_valid_wr = vwr_d;
    assign busy                  = pend || (state_q != ST_IDLE);
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_lbeacon_gen.sv
// Directed bench for lbeacon_gen: table-driven packet vectors plus hand-written
// back-pressure, overwrite, mid-packet, auto-resend, seq wrap and reset sequences.
module tb_lbeacon_gen;
    import lbeacon_gen_pkg::*;

    localparam logic [47:0] LOCAL_MAC = 48'hAABBCCDDEEFF;
    localparam logic [47:0] TIME0     = 48'h112233445566;

    typedef struct {
        logic [47:0]  dst;
        logic         dir;
        logic [15:0]  para;
        logic [15:0]  depth;
        logic [47:0]  direct;
        logic [31:0]  slot;
        logic [127:0] b0;
        logic [127:0] b1;
        logic [127:0] b2;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_wr = 1'b0;
    logic [47:0]  cfg_dst_mac = '0;
    logic         cfg_direction = 1'b0;
    logic [15:0]  cfg_tb_para = '0;
    logic [15:0]  cfg_tb_depth = '0;
    logic [47:0]  cfg_direct_mac = '0;
    logic [31:0]  cfg_slot_period = '0;
    logic [31:0]  beacon_period = '0;
    logic [47:0]  in_local_mac_id = LOCAL_MAC;
    logic [47:0]  precision_time = TIME0;
    logic         busy;
    logic [31:0]  out_pkt_cnt;
    logic [15:0]  overwrite_cnt;
    state_t       dbg_state;

    lbeacon_gen_if pkt_if ();

    lbeacon_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_wr          (cfg_wr),
        .cfg_dst_mac     (cfg_dst_mac),
        .cfg_direction   (cfg_direction),
        .cfg_tb_para     (cfg_tb_para),
        .cfg_tb_depth    (cfg_tb_depth),
        .cfg_direct_mac  (cfg_direct_mac),
        .cfg_slot_period (cfg_slot_period),
        .beacon_period   (beacon_period),
        .in_local_mac_id (in_local_mac_id),
        .precision_time  (precision_time),
        .pkt             (pkt_if),
        .busy            (busy),
        .out_pkt_cnt     (out_pkt_cnt),
        .overwrite_cnt   (overwrite_cnt),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [133:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic         mon_en = 1'b1;

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && pkt_if.out_data_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL extra_beat: got %h expected no beat", pkt_if.out_data);
            end else begin
                chk("beat_data", pkt_if.out_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input cfg_t c);
        cfg_dst_mac     = c.dst_mac;
        cfg_direction   = c.direction;
        cfg_tb_para     = c.tb_para;
        cfg_tb_depth    = c.tb_depth;
        cfg_direct_mac  = c.direct_mac;
        cfg_slot_period = c.slot_period;
    endtask

    task automatic pulse_cfg(input cfg_t c);
        drive_cfg(c);
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    // Reference packet built from field values (independent of the DUT).
    task automatic push_pkt(input cfg_t c, input logic [7:0] s, input logic [47:0] t);
        exp_q.push_back({2'b01, 4'b0, c.dst_mac, LOCAL_MAC, 16'h9001, 8'h02, s});
        exp_q.push_back({2'b11, 4'b0, 8'h01, 7'b0, c.direction, c.tb_para, c.tb_depth,
                         c.slot_period, 48'b0});
        exp_q.push_back({2'b11, 4'b0, c.direct_mac, t, 32'b0});
        exp_q.push_back({2'b10, 4'b0, 128'b0});
    endtask

    function automatic cfg_t vec_cfg(input vec_t v);
        cfg_t c;
        c.dst_mac     = v.dst;
        c.direction   = v.dir;
        c.tb_para     = v.para;
        c.tb_depth    = v.depth;
        c.direct_mac  = v.direct;
        c.slot_period = v.slot;
        return c;
    endfunction

    function automatic logic [2:0] wr_hdr();
        logic [133:0] d;
        d = pkt_if.out_data;
        return {pkt_if.out_data_wr, d[133:132]};
    endfunction

    // ---------------- test ----------------
    vec_t       vecs[3];
    cfg_t       ca, cb, cc;
    logic [7:0] tb_seq = 8'd0;
    int         pkt_total = 0;
    int         heads;
    int         wr_seen;

    initial begin
        vecs[0] = '{48'h0A0B0C0D0E0F, 1'b1, 16'h0010, 16'h0100, 48'h000000000000, 32'h0000000A,
                    128'h0A0B0C0D0E0F_AABBCCDDEEFF_9001_02_00,
                    128'h01_01_0010_0100_0000000A_000000000000,
                    128'h000000000000_112233445566_00000000};
        vecs[1] = '{48'h123456789ABC, 1'b0, 16'hFFFF, 16'h0001, 48'h0E0D0C0B0A09, 32'h00000010,
                    128'h123456789ABC_AABBCCDDEEFF_9001_02_01,
                    128'h01_00_FFFF_0001_00000010_000000000000,
                    128'h0E0D0C0B0A09_112233445566_00000000};
        vecs[2] = '{48'hFFFFFFFFFFFF, 1'b1, 16'h8000, 16'h7FFF, 48'h000000000001, 32'h00000007,
                    128'hFFFFFFFFFFFF_AABBCCDDEEFF_9001_02_02,
                    128'h01_01_8000_7FFF_00000007_000000000000,
                    128'h000000000001_112233445566_00000000};
        ca = vec_cfg(vecs[0]);
        cb = vec_cfg(vecs[1]);
        cc = vec_cfg(vecs[2]);
        pkt_if.in_ready = 1'b1;

        // reset state
        #12;
        chk("rst_data", pkt_if.out_data, 134'd0);
        chk("rst_wr", {pkt_if.out_data_wr, pkt_if.out_data_valid, pkt_if.out_data_valid_wr}, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnts", {out_pkt_cnt, overwrite_cnt}, 48'd0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        step();

        // table-driven single requests
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({2'b01, 4'b0, vecs[i].b0});
            exp_q.push_back({2'b11, 4'b0, vecs[i].b1});
            exp_q.push_back({2'b11, 4'b0, vecs[i].b2});
            exp_q.push_back({2'b10, 4'b0, 128'b0});
            pulse_cfg(vec_cfg(vecs[i]));
            chk("c1_pending", {busy, pkt_if.out_data_wr}, 2'b10);
            step();
            chk("c2_head", wr_hdr(), 3'b101);
            chk("c2_no_valid", pkt_if.out_data_valid_wr, 1'b0);
            step();
            precision_time = 48'hDEADBEEF0000;
            chk("c3_body", wr_hdr(), 3'b111);
            step();
            chk("c4_body", wr_hdr(), 3'b111);
            step();
            chk("c5_tail", wr_hdr(), 3'b110);
            chk("c5_valid", {pkt_if.out_data_valid_wr, pkt_if.out_data_valid}, 2'b11);
            precision_time = TIME0;
            step();
            pkt_total++;
            chk("c6_idle", {pkt_if.out_data_wr, busy}, 2'b00);
            chk("c6_pkt_cnt", out_pkt_cnt, pkt_total);
        end
        tb_seq = 8'd3;

        // back-pressure: request held while in_ready is low
        pkt_if.in_ready = 1'b0;
        push_pkt(ca, tb_seq, TIME0);
        tb_seq++;
        pulse_cfg(ca);
        wr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (pkt_if.out_data_wr !== 1'b0 || busy !== 1'b1) wr_seen++;
            step();
        end
        chk("bp_hold", wr_seen, 0);
        pkt_if.in_ready = 1'b1;
        step();
        chk("bp_head", wr_hdr(), 3'b101);
        repeat (5) step();
        pkt_total++;
        chk("bp_done", {busy, out_pkt_cnt}, {1'b0, 32'(pkt_total)});

        // overwrite: three requests while blocked, only the last is sent
        pkt_if.in_ready = 1'b0;
        drive_cfg(ca);
        cfg_wr = 1'b1;
        step();
        drive_cfg(cb);
        step();
        drive_cfg(cc);
        step();
        cfg_wr = 1'b0;
        chk("ovw_cnt", overwrite_cnt, 16'd2);
        push_pkt(cc, tb_seq, TIME0);
        tb_seq++;
        pkt_if.in_ready = 1'b1;
        repeat (8) step();
        pkt_total++;
        chk("ovw_pkt_cnt", out_pkt_cnt, pkt_total);

        // request during B1: second packet after one idle cycle
        push_pkt(ca, tb_seq, TIME0);
        push_pkt(cb, tb_seq + 8'd1, TIME0);
        tb_seq += 8'd2;
        pulse_cfg(ca);
        step();
        step();
        chk("mid_b1", wr_hdr(), 3'b111);
        drive_cfg(cb);
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        step();
        chk("mid_tail", wr_hdr(), 3'b110);
        step();
        chk("mid_gap", {pkt_if.out_data_wr, busy}, 2'b01);
        step();
        chk("mid_head2", wr_hdr(), 3'b101);
        repeat (5) step();
        pkt_total += 2;
        chk("mid_ovw", overwrite_cnt, 16'd2);

        // request on the consume cycle is not an overwrite
        push_pkt(cb, tb_seq, TIME0);
        push_pkt(cc, tb_seq + 8'd1, TIME0);
        tb_seq += 8'd2;
        drive_cfg(cb);
        cfg_wr = 1'b1;
        step();
        drive_cfg(cc);
        step();
        cfg_wr = 1'b0;
        repeat (10) step();
        pkt_total += 2;
        chk("cons_ovw", overwrite_cnt, 16'd2);
        chk("cons_pkt_cnt", out_pkt_cnt, pkt_total);

        // auto-resend every 100 cycles, then disable
        for (int k = 0; k < 3; k++) push_pkt(ca, tb_seq + 8'(k), TIME0);
        tb_seq += 8'd3;
        drive_cfg(ca);
        beacon_period = 32'd100;
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        heads = 0;
        for (int cyc = 1; cyc < 260; cyc++) begin
            if (wr_hdr() == 3'b101) heads++;
            if (cyc == 2 || cyc == 102 || cyc == 202) chk("auto_head_time", wr_hdr(), 3'b101);
            step();
        end
        chk("auto_heads", heads, 3);
        pkt_total += 3;
        beacon_period = 32'd0;
        wr_seen = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (pkt_if.out_data_wr === 1'b1) wr_seen++;
            step();
        end
        chk("auto_stopped", wr_seen, 0);

        // 256 resends at period 8: seq runs through FF -> 00
        for (int k = 0; k < 256; k++) push_pkt(cb, tb_seq + 8'(k), TIME0);
        drive_cfg(cb);
        beacon_period = 32'd8;
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        heads = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (wr_hdr() == 3'b101) heads++;
            if (heads == 256) break;
            step();
        end
        beacon_period = 32'd0;
        chk("wrap_heads", heads, 256);
        repeat (10) step();
        pkt_total += 256;
        chk("wrap_pkt_cnt", out_pkt_cnt, pkt_total);
        chk("wrap_q_empty", exp_q.size(), 0);

        // asynchronous reset during B2 abandons the packet
        mon_en = 1'b0;
        beacon_period = 32'd20;
        pulse_cfg(cc);
        step();
        step();
        step();
        chk("rst_b2", wr_hdr(), 3'b111);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", {pkt_if.out_data_wr, pkt_if.out_data_valid_wr, pkt_if.out_data}, 136'd0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_cnt", out_pkt_cnt, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        wr_seen = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (pkt_if.out_data_wr === 1'b1 || busy === 1'b1) wr_seen++;
            step();
        end
        chk("rst_no_resend", wr_seen, 0);
        beacon_period = 32'd0;
        push_pkt(ca, 8'd0, TIME0);
        pulse_cfg(ca);
        repeat (8) step();
        chk("rst_new_pkt", out_pkt_cnt, 32'd1);
        chk("final_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
